nand_gate_checker: RTL and testbench
====================================

// Module: nand_gate_checker
// PURPOSE
//  Self-checking driver/monitor for a 2-input NAND cell.
//  Drives A/B with the exhaustive truth-table sequence 00,01,10,11 and waits a settle window.
//  Samples Y and compares it to ~(A&B); counts mismatches and reports pass/fail.
//  Sits opposite the gate under test, as its on-chip stimulus and response end, for silicon or FPGA bring-up of library cells.
// PARAMETERS
//  SETTLE_CYCLES  2    clk cycles between driving a vector and sampling y_in (0..255; 0 = sample next cycle)
//  LOOPS          1    full 4-vector passes per run (1..65535)
//  ERR_W          8    width of err_cnt; saturating
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  start          in   1      run request; sampled only in IDLE or DONE
//  a_out          out  1      drive to gate input A
//  b_out          out  1      drive to gate input B
//  y_in           in   1      gate output Y (synchronous to clk, settled by SETTLE_CYCLES)
//  busy           out  1      high from the cycle after start is accepted until done rises
//  done           out  1      high and held after a run completes, until next accepted start
//  pass           out  1      valid while done=1: 1 iff err_cnt==0
//  err_cnt        out  ERR_W  mismatch count of current/last run, saturates at all-ones
//  first_err_vec  out  2      {A,B} of first mismatch in run; 2'b00 if none (qualify with err_cnt)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, a_out=b_out=0, busy=done=pass=0,
//   err_cnt=0, first_err_vec=0, vec=0, loop=0, settle count=0.
//  FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
//   IDLE/DONE, start=1 -> DRIVE: clear err_cnt, first_err_vec, vec, loop; done=0, busy=1.
//   DRIVE (1 cycle): {a_out,b_out}<=vec. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
//   SETTLE: stays for exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
//   SAMPLE (1 cycle): compare y_in with ~(a_out&b_out).
//    On mismatch, err_cnt+1 (saturating). If it is the first mismatch, latch first_err_vec<=vec.
//    If vec==3 and loop==LOOPS-1, go to DONE. Otherwise advance vec (wraps 3->0).
//    When vec wraps, loop+1. Then go to DRIVE.
//   DONE: busy=0, done=1, pass=(err_cnt==0). a_out/b_out hold the last vector (1,1).
//  Latency: done rises exactly LOOPS*4*(SETTLE_CYCLES+2) cycles after the edge sampling start.
//  Per vector, DRIVE plus SETTLE plus SAMPLE takes SETTLE_CYCLES+2 cycles.
//  start while busy: ignored, no restart, no effect on counters.
//  start held high: one run per acceptance. In DONE it immediately re-arms a new run.
//  The mismatch in the same SAMPLE that saturates err_cnt is still counted to all-ones, never wraps.
//  rst_n low mid-run: all state cleared immediately, to the reset values above. No partial result kept.
//  pass is 0 whenever done=0.
// STRUCTURE
//  Package gate_chk_pkg holds:
//   - FSM state encoding constants (3-bit, IDLE=0).
//   - Vector constants VEC_00..VEC_11.
//   - Function nand_ref(a,b) used for the expected value.
//  One sub-module, gate_chk_settle_cnt: a loadable down-counter with ports load, en, zero. It times SETTLE.
//  Everything else lives in nand_gate_checker: FSM, vector/loop counters, error accumulator.
// TESTING (bench instantiates nand_gate_checker driving a good NAND or a fault model)
//  1. Good NAND, SETTLE_CYCLES=2, LOOPS=1, 1-cycle start:
//     busy=1 next cycle, done=1 at cycle 16, pass=1, err_cnt=0.
//     a_out/b_out step 00,01,10,11 every 4 cycles.
//  2. y_in stuck-at-1: err_cnt=1, first_err_vec=2'b11, pass=0 at done.
//  3. y_in stuck-at-0: err_cnt=3, first_err_vec=2'b00, pass=0.
//  4. Saturation, y stuck-at-0 with LOOPS=100, SETTLE_CYCLES=0:
//     err_cnt=255 at done (not 44), done at cycle 800.
//  5. start pulsed again at cycle 5 of a run: ignored, done still at 16.
//     start in DONE clears err_cnt and reruns.
//  6. rst_n low at cycle 7 mid-run: all outputs return to reset values within the same cycle (async).
//     A new start after release completes normally with pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// ============================================================================
// gate_chk_pkg : shared types, vector constants and the NAND reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] VEC_00 = 2'b00;
  localparam logic [1:0] VEC_01 = 2'b01;
  localparam logic [1:0] VEC_10 = 2'b10;
  localparam logic [1:0] VEC_11 = 2'b11;

  function automatic logic nand_ref(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_chk_settle_cnt.sv
// ============================================================================
// gate_chk_settle_cnt : loadable down-counter that times the settle window
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module gate_chk_settle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/nand_gate_checker.sv
// ============================================================================
// nand_gate_checker : exhaustive stimulus/response checker for a 2-input NAND
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module nand_gate_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_err_vec
);

  localparam int         LOOP_W      = 16;
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);

  state_e             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [1:0]         fev_q, fev_d;

  logic settle_load;
  logic settle_en;
  logic settle_zero;
  logic mismatch;

  // Loaded with SETTLE_CYCLES-1 in DRIVE so SETTLE lasts exactly SETTLE_CYCLES cycles.
  gate_chk_settle_cnt #(
    .W (8)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (settle_en),
    .zero     (settle_zero)
  );

  assign mismatch = (y_in != nand_ref(a_q, b_q));

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    loop_d      = loop_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    fev_d       = fev_q;
    settle_load = 1'b0;
    settle_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          err_d   = '0;
          fev_d   = VEC_00;
          vec_d   = VEC_00;
          loop_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_DRIVE: begin
        a_d         = vec_q[1];
        b_d         = vec_q[0];
        settle_load = 1'b1;
        state_d     = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_en = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q == '0) begin
            fev_d = vec_q;
          end
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if ((vec_q == VEC_11) && (loop_q == LAST_LOOP)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + 2'd1;
          if (vec_q == VEC_11) begin
            loop_d = loop_q + LOOP_W'(1);
          end
          state_d = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= VEC_00;
      loop_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= VEC_00;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
    end
  end

  assign a_out         = a_q;
  assign b_out         = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = done_q & (err_q == '0);
  assign err_cnt       = err_q;
  assign first_err_vec = fev_q;

endmodule

`default_nettype wire

// File: tb/tb_nand_gate_checker.sv
// ============================================================================
// tb_nand_gate_checker : scoreboard bench with good and faulty NAND models
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_nand_gate_checker;

  typedef struct {
    int err;
    int fvec;
    int pass;
    int lat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       big;
  logic [1:0] mode;   // 0 good NAND, 1 stuck-at-1, 2 stuck-at-0

  logic       a1, b1, y1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [1:0] fev1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [7:0] err2;
  logic [1:0] fev2;

  int n_checks;
  int n_fail;
  exp_t sb[$];

  assign y1 = (mode == 2'd0) ? ~(a1 & b1) : (mode == 2'd1);
  assign y2 = (mode == 2'd0) ? ~(a2 & b2) : (mode == 2'd1);

  nand_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~big), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_vec(fev1)
  );

  nand_gate_checker #(.SETTLE_CYCLES(0), .LOOPS(100), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & big), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_vec(fev2)
  );

  wire       o_busy = big ? busy2 : busy1;
  wire       o_done = big ? done2 : done1;
  wire       o_pass = big ? pass2 : pass1;
  wire [7:0] o_err  = big ? err2  : err1;
  wire [1:0] o_fev  = big ? fev2  : fev1;
  wire [1:0] o_ab   = big ? {a2, b2} : {a1, b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int md, input int loops, input int settle);
    exp_t e;
    e.err  = 0;
    e.fvec = 0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        int good;
        int y;
        good = ((v == 3) ? 0 : 1);
        y    = (md == 0) ? good : ((md == 1) ? 1 : 0);
        if (y != good) begin
          if (e.err == 0) e.fvec = v;
          if (e.err != 255) e.err++;
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = loops * 4 * (settle + 2);
    return e;
  endfunction

  task automatic run(input bit sel_big, input logic [1:0] md, input bit chk_vec,
                     input bit repulse, input bit do_rst);
    exp_t e;
    big  = sel_big;
    mode = md;
    if (!do_rst) sb.push_back(sel_big ? model(md, 100, 0) : model(md, 1, 2));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("done_after_start", o_done, 0);
    chk("err_clr_on_start", o_err, 0);
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (chk_vec && (n % 4 == 1)) chk("vec_step", o_ab, (n - 1) / 4);
      if (repulse && n == 5) start = 1'b1;
      if (repulse && n == 6) start = 1'b0;
      if (do_rst && n == 7) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ab", {a1, b1}, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done_pass", {done1, pass1}, 0);
        chk("rst_err_fev", {err1, fev1}, 0);
        #2;
        rst_n = 1'b1;
        return;
      end
      if (o_done) begin
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("err_cnt", o_err, e.err);
        chk("first_err_vec", o_fev, e.fvec);
        chk("pass", o_pass, e.pass);
        chk("busy_at_done", o_busy, 0);
        chk("ab_hold_11", o_ab, 3);
        return;
      end
    end
    chk("timeout", 0, 1);
    void'(sb.pop_front());
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    big      = 1'b0;
    mode     = 2'd0;
    #12;
    chk("reset_dut1", {a1, b1, busy1, done1, pass1, err1, fev1}, 0);
    chk("reset_dut2", {a2, b2, busy2, done2, pass2, err2, fev2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);  // good NAND, vector stepping checked
    run(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);  // stuck-at-1
    run(1'b0, 2'd2, 1'b0, 1'b0, 1'b0);  // stuck-at-0, rerun from DONE clears count
    run(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);  // saturation
    run(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);  // start while busy ignored
    run(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);  // reset mid-run
    @(negedge clk);
    run(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);  // clean run after reset

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
